// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART ASCII command parser: FSM states, ASCII control
// codes, keyword characters and small character-class helpers.
package uart_cmd_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DECODE  = 2'd2;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_DEL   = 8'h7F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  // Bit positions in the one-hot keyword match vector.
  localparam int unsigned MATCH_W = 4;
  localparam int unsigned M_WATCH = 0;
  localparam int unsigned M_SR04  = 1;
  localparam int unsigned M_TEMP  = 2;
  localparam int unsigned M_HUM   = 3;

  // Keywords with the first character in element [0].
  localparam logic [4:0][7:0] KW_WATCH = {8'h48, 8'h43, 8'h54, 8'h41, 8'h57};
  localparam logic [3:0][7:0] KW_SR04  = {8'h34, 8'h30, 8'h52, 8'h53};
  localparam logic [3:0][7:0] KW_TEMP  = {8'h50, 8'h4D, 8'h45, 8'h54};
  localparam logic [2:0][7:0] KW_HUM   = {8'h4D, 8'h55, 8'h48};

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
  endfunction

endpackage

// File: rtl/uart_cmd_match.sv
// Combinational keyword matcher: compares the first count characters of the
// line buffer against each keyword, requiring an exact length match.
module uart_cmd_match
  import uart_cmd_pkg::*;
#(
  parameter int unsigned P_LINE_MAX = 8
) (
  input  logic [P_LINE_MAX-1:0][7:0]          line_i,
  input  logic [$clog2(P_LINE_MAX+1)-1:0]     count_i,
  output logic [MATCH_W-1:0]                  match_o,
  output logic                                no_match_o
);

  localparam int unsigned PAD_N = (P_LINE_MAX > 5) ? P_LINE_MAX : 5;
  localparam int unsigned PAD_W = PAD_N * 8;

  localparam logic [PAD_N-1:0][7:0] PAD_WATCH = PAD_W'(KW_WATCH);
  localparam logic [PAD_N-1:0][7:0] PAD_SR04  = PAD_W'(KW_SR04);
  localparam logic [PAD_N-1:0][7:0] PAD_TEMP  = PAD_W'(KW_TEMP);
  localparam logic [PAD_N-1:0][7:0] PAD_HUM   = PAD_W'(KW_HUM);

  logic [31:0]             len;
  logic [PAD_N-1:0][7:0]   line_pad;

  assign len = 32'(count_i);

  // Stale characters beyond count are masked so a whole-vector compare is exact.
  always_comb begin
    line_pad = '0;
    for (int unsigned i = 0; i < P_LINE_MAX; i++) begin
      if (i < len) line_pad[i] = line_i[i];
    end
  end

  assign match_o[M_WATCH] = (len == 32'd5) && (line_pad == PAD_WATCH);
  assign match_o[M_SR04]  = (len == 32'd4) && (line_pad == PAD_SR04);
  assign match_o[M_TEMP]  = (len == 32'd4) && (line_pad == PAD_TEMP);
  assign match_o[M_HUM]   = (len == 32'd3) && (line_pad == PAD_HUM);
  assign no_match_o       = ~|match_o;

endmodule

// File: rtl/uart_ascii_cmd_parser.sv
// Pops bytes from an RX FIFO, optionally echoes them, assembles an upper-cased
// command line and pulses a report request or error on CR/LF.
module uart_ascii_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned P_LINE_MAX = 8,
  parameter bit          P_ECHO_EN  = 1'b1
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRxFifoEmpty,
  input  logic [7:0] iRxData,
  output logic       oRxPop,
  output logic [7:0] oLoopData,
  output logic       oLoopValid,
  output logic       oReqWatchReport,
  output logic       oReqSr04Report,
  output logic       oReqTempReport,
  output logic       oReqHumReport,
  output logic       oCmdError
);

  localparam int unsigned      CNT_W   = $clog2(P_LINE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_LINE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]                 state_q, state_d;
  logic [7:0]                 byte_q, byte_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [P_LINE_MAX-1:0][7:0] line_q, line_d;
  logic [7:0]                 loop_data_q, loop_data_d;
  logic                       loop_valid_q, loop_valid_d;
  logic [MATCH_W-1:0]         req_q, req_d;
  logic                       err_q, err_d;
  logic [MATCH_W-1:0]         match;
  logic                       no_match;

  uart_cmd_match #(
    .P_LINE_MAX (P_LINE_MAX)
  ) u_match (
    .line_i     (line_q),
    .count_i    (count_q),
    .match_o    (match),
    .no_match_o (no_match)
  );

  // The FIFO returns data the cycle after the pop, which is the capture cycle.
  assign oRxPop = (state_q == ST_IDLE) && !iRxFifoEmpty && !iRst;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    byte_d       = byte_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    line_d       = line_q;
    loop_data_d  = loop_data_q;
    loop_valid_d = 1'b0;
    req_d        = '0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!iRxFifoEmpty) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        byte_d  = iRxData;
        state_d = ST_DECODE;
        if (P_ECHO_EN) begin
          loop_data_d  = iRxData;
          loop_valid_d = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (byte_q == ASCII_CR || byte_q == ASCII_LF) begin
          if (overflow_q || (count_q != '0 && no_match)) err_d = 1'b1;
          else if (count_q != '0)                         req_d = match;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (byte_q == ASCII_BS || byte_q == ASCII_DEL) begin
          if (count_q != '0) begin
            count_d    = count_q - CNT_ONE;
            overflow_d = 1'b0;
          end
        end else if (is_printable(byte_q)) begin
          if (count_q < CNT_MAX) begin
            for (int unsigned i = 0; i < P_LINE_MAX; i++) begin
              if (32'(count_q) == i) line_d[i] = to_upper(byte_q);
            end
            count_d = count_q + CNT_ONE;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (iRst) begin
      state_q      <= ST_IDLE;
      byte_q       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      // NOTE: the line buffer is small and must read as all-zero after reset, so it is reset like any register.
      line_q       <= '0;
      loop_data_q  <= '0;
      loop_valid_q <= 1'b0;
      req_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      line_q       <= line_d;
      loop_data_q  <= loop_data_d;
      loop_valid_q <= loop_valid_d;
      req_q        <= req_d;
      err_q        <= err_d;
    end
  end

  assign oLoopData       = loop_data_q;
  assign oLoopValid      = loop_valid_q;
  assign oReqWatchReport = req_q[M_WATCH];
  assign oReqSr04Report  = req_q[M_SR04];
  assign oReqTempReport  = req_q[M_TEMP];
  assign oReqHumReport   = req_q[M_HUM];
  assign oCmdError       = err_q;

endmodule
